// File: rtl/cache_request_arbiter.sv
// cache_request_arbiter: round-robin sharing of one L1 cache port between two requesters,
// sequencing each access through ACCESS and an enable-low RELEASE gap, with miss counting.
module cache_request_arbiter #(
    parameter int ADDR_LENGTH  = 10,
    parameter int BLOCK_SIZE   = 32,
    parameter int RETURN_SIZE  = 8,
    parameter int WRITE_CYCLES = 4,
    parameter int TIMEOUT      = 255,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   write0,
    input  logic                   write1,
    input  logic [ADDR_LENGTH-1:0] addr0,
    input  logic [ADDR_LENGTH-1:0] addr1,
    input  logic [BLOCK_SIZE-1:0]  wdata0,
    input  logic [BLOCK_SIZE-1:0]  wdata1,
    output logic                   done0,
    output logic                   done1,
    output logic [RETURN_SIZE-1:0] rdata0,
    output logic [RETURN_SIZE-1:0] rdata1,
    output logic                   err0,
    output logic                   err1,
    output logic                   cache_enable,
    output logic                   cache_write,
    output logic [ADDR_LENGTH-1:0] cache_addr,
    output logic [BLOCK_SIZE-1:0]  cache_wdata,
    input  logic [RETURN_SIZE-1:0] cache_rdata,
    input  logic                   cache_fetchComplete,
    input  logic                   cache_miss,
    output logic                   busy,
    output logic                   owner,
    output logic [15:0]            miss_count
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic                   owner_q, owner_d;
    logic                   busy_q, busy_d;
    logic                   en_q, en_d;
    logic                   wr_q, wr_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [BLOCK_SIZE-1:0]  wdata_q, wdata_d;
    logic [RETURN_SIZE-1:0] rdata0_q, rdata0_d;
    logic [RETURN_SIZE-1:0] rdata1_q, rdata1_d;
    logic                   done0_q, done0_d;
    logic                   done1_q, done1_d;
    logic                   err0_q, err0_d;
    logic                   err1_q, err1_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   miss_flag_q, miss_flag_d;
    logic [15:0]            miss_count_q, miss_count_d;

    logic gnt1, rd_done, wr_done, tmo, exit_acc, miss_seen;

    // Requester 1 wins when it is alone or when both ask and the pointer favours it.
    assign gnt1      = req1 & (~req0 | ptr_q);
    assign rd_done   = ~wr_q & cache_fetchComplete;
    assign wr_done   = wr_q & (cnt_q == CW'(WRITE_CYCLES));
    assign tmo       = ~rd_done & ~wr_done & (cnt_q == CW'(TIMEOUT));
    assign exit_acc  = rd_done | wr_done | tmo;
    assign miss_seen = miss_flag_q | cache_miss;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        en_d         = en_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        miss_flag_d  = miss_flag_q;
        miss_count_d = miss_count_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d     = ACCESS;
                    owner_d     = gnt1;
                    ptr_d       = ~gnt1;
                    en_d        = 1'b1;
                    wr_d        = gnt1 ? write1 : write0;
                    addr_d      = gnt1 ? addr1 : addr0;
                    wdata_d     = gnt1 ? wdata1 : wdata0;
                    cnt_d       = CW'(1);
                    miss_flag_d = 1'b0;
                end
            end
            ACCESS: begin
                miss_flag_d = miss_seen;
                cnt_d       = cnt_q + CW'(1);
                if (exit_acc) begin
                    state_d     = RELEASE;
                    en_d        = 1'b0;
                    wr_d        = 1'b0;
                    gap_d       = GW'(1);
                    miss_flag_d = 1'b0;
                    done0_d     = ~owner_q;
                    done1_d     = owner_q;
                    err0_d      = tmo & ~owner_q;
                    err1_d      = tmo & owner_q;
                    rdata0_d    = (rd_done & ~owner_q) ? cache_rdata : rdata0_q;
                    rdata1_d    = (rd_done & owner_q) ? cache_rdata : rdata1_q;
                    miss_count_d = (miss_seen && miss_count_q != 16'hFFFF) ? miss_count_q + 16'd1 : miss_count_q;
                end
            end
            RELEASE: begin
                if (gap_q >= GW'(GAP_CYCLES)) state_d = IDLE;
                else gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            en_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            cnt_q        <= '0;
            gap_q        <= '0;
            miss_flag_q  <= 1'b0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            en_q         <= en_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            miss_flag_q  <= miss_flag_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign done0        = done0_q;
    assign done1        = done1_q;
    assign err0         = err0_q;
    assign err1         = err1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign cache_enable = en_q;
    assign cache_write  = wr_q;
    assign cache_addr   = addr_q;
    assign cache_wdata  = wdata_q;
    assign busy         = busy_q;
    assign owner        = owner_q;
    assign miss_count   = miss_count_q;
endmodule

// File: tb/tb_cache_request_arbiter.sv
// tb_cache_request_arbiter: directed scenarios with hand-computed expectations for the
// round-robin cache port arbiter (default parameters).
module tb_cache_request_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
    logic [9:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1;
    logic [7:0]  rdata0, rdata1;
    logic        cache_enable, cache_write;
    logic [9:0]  cache_addr;
    logic [31:0] cache_wdata;
    logic [7:0]  cache_rdata = '0;
    logic        cache_fetchComplete = 1'b0, cache_miss = 1'b0;
    logic        busy, owner;
    logic [15:0] miss_count;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_request_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .cache_enable(cache_enable), .cache_write(cache_write),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata), .cache_fetchComplete(cache_fetchComplete),
        .cache_miss(cache_miss),
        .busy(busy), .owner(owner), .miss_count(miss_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (cache_enable !== 1'b0) begin fails++; $display("FAIL reset_enable got %b want 0", cache_enable); end
        tests++; if (owner !== 1'b0) begin fails++; $display("FAIL reset_owner got %b want 0", owner); end
        tests++; if (miss_count !== 16'h0000) begin fails++; $display("FAIL reset_miss_count got %h want 0000", miss_count); end
        tests++; if ({rdata0, rdata1} !== 16'h0000) begin fails++; $display("FAIL reset_rdata got %h want 0000", {rdata0, rdata1}); end
        tests++; if ({done0, done1, err0, err1, cache_write} !== 5'b0) begin fails++; $display("FAIL reset_pulses got %b want 00000", {done0, done1, err0, err1, cache_write}); end
        tests++; if ({cache_addr, cache_wdata} !== 42'h0) begin fails++; $display("FAIL reset_addr_wdata got %h want 0", {cache_addr, cache_wdata}); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_read();
        int en_cnt;
        req0 = 1'b1; write0 = 1'b0; addr0 = 10'h020;
        tick();
        tests++; if ({cache_enable, busy, owner} !== 3'b110) begin fails++; $display("FAIL read_grant en/busy/owner got %b want 110", {cache_enable, busy, owner}); end
        tests++; if (cache_addr !== 10'h020) begin fails++; $display("FAIL read_addr got %h want 020", cache_addr); end
        en_cnt = int'(cache_enable);
        tick(); en_cnt += int'(cache_enable);
        tick(); en_cnt += int'(cache_enable);
        cache_fetchComplete = 1'b1; cache_rdata = 8'hA5;
        tick();
        tests++; if (en_cnt !== 3) begin fails++; $display("FAIL read_enable_cycles got %0d want 3", en_cnt); end
        tests++; if ({done0, done1, err0, cache_enable} !== 4'b1000) begin fails++; $display("FAIL read_done done0/done1/err0/en got %b want 1000", {done0, done1, err0, cache_enable}); end
        tests++; if (rdata0 !== 8'hA5) begin fails++; $display("FAIL read_rdata0 got %h want a5", rdata0); end
        tests++; if (miss_count !== 16'h0) begin fails++; $display("FAIL read_miss_count got %h want 0000", miss_count); end
        req0 = 1'b0; cache_fetchComplete = 1'b0;
        tick();
        tests++; if ({done0, cache_enable, busy} !== 3'b000) begin fails++; $display("FAIL read_after done0/en/busy got %b want 000", {done0, cache_enable, busy}); end
    endtask

    task automatic test_contention();
        logic exp_o;
        apply_reset();
        req0 = 1'b1; req1 = 1'b1; write0 = 1'b0; write1 = 1'b0;
        addr0 = 10'h011; addr1 = 10'h022;
        for (int k = 0; k < 4; k++) begin
            exp_o = k[0];
            tick();
            tests++; if ({owner, cache_enable} !== {exp_o, 1'b1}) begin fails++; $display("FAIL rr_grant%0d owner/en got %b want %b1", k, {owner, cache_enable}, exp_o); end
            tests++; if (cache_addr !== (exp_o ? 10'h022 : 10'h011)) begin fails++; $display("FAIL rr_addr%0d got %h want %h", k, cache_addr, exp_o ? 10'h022 : 10'h011); end
            cache_fetchComplete = 1'b1; cache_rdata = 8'(k + 16);
            tick();
            tests++; if ({done0, done1, cache_enable} !== {~exp_o, exp_o, 1'b0}) begin fails++; $display("FAIL rr_done%0d done0/done1/en got %b want %b%b0", k, {done0, done1, cache_enable}, ~exp_o, exp_o); end
            tests++; if ((exp_o ? rdata1 : rdata0) !== 8'(k + 16)) begin fails++; $display("FAIL rr_rdata%0d got %h want %h", k, exp_o ? rdata1 : rdata0, 8'(k + 16)); end
            cache_fetchComplete = 1'b0;
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            tick();
            tests++; if ({cache_enable, busy} !== 2'b00) begin fails++; $display("FAIL rr_gap%0d en/busy got %b want 00", k, {cache_enable, busy}); end
        end
    endtask

    task automatic test_write();
        int wcnt, dcnt, ecnt;
        req1 = 1'b1; write1 = 1'b1; addr1 = 10'h004; wdata1 = 32'hFFFFFFFF;
        tick();
        addr1 = 10'h3FF; wdata1 = 32'h0; write1 = 1'b0;
        wcnt = 0; dcnt = 0; ecnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (cache_write && cache_wdata == 32'hFFFFFFFF && cache_addr == 10'h004) wcnt++;
            if (done1) begin dcnt++; req1 = 1'b0; end
            ecnt += int'(err1);
            tick();
        end
        tests++; if (wcnt !== 4) begin fails++; $display("FAIL write_cycles got %0d want 4", wcnt); end
        tests++; if (dcnt !== 1) begin fails++; $display("FAIL write_done_count got %0d want 1", dcnt); end
        tests++; if (ecnt !== 0) begin fails++; $display("FAIL write_err_count got %0d want 0", ecnt); end
        tests++; if (rdata1 !== 8'h13) begin fails++; $display("FAIL write_rdata1 got %h want 13", rdata1); end
        tests++; if ({cache_write, cache_enable, busy, owner} !== 4'b0001) begin fails++; $display("FAIL write_end wr/en/busy/owner got %b want 0001", {cache_write, cache_enable, busy, owner}); end
    endtask

    task automatic test_miss();
        req0 = 1'b1; write0 = 1'b0; addr0 = 10'h100;
        tick();
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) begin
                tests++; if (miss_count !== 16'h0) begin fails++; $display("FAIL miss_early got %h want 0000", miss_count); end
            end
            cache_miss = (c >= 2);
            cache_fetchComplete = (c == 20);
            cache_rdata = 8'h77;
            tick();
        end
        tests++; if ({done0, cache_enable} !== 2'b10) begin fails++; $display("FAIL miss_done done0/en got %b want 10", {done0, cache_enable}); end
        tests++; if (miss_count !== 16'h0001) begin fails++; $display("FAIL miss_count got %h want 0001", miss_count); end
        tests++; if (rdata0 !== 8'h77) begin fails++; $display("FAIL miss_rdata0 got %h want 77", rdata0); end
        cache_miss = 1'b0; cache_fetchComplete = 1'b0; req0 = 1'b0;
        tick();
        force dut.miss_count_q = 16'hFFFE;
        #1;
        release dut.miss_count_q;
        for (int j = 0; j < 2; j++) begin
            req0 = 1'b1;
            tick();
            cache_miss = 1'b1; cache_fetchComplete = 1'b1; cache_rdata = 8'h5A;
            tick();
            tests++; if ({done0, miss_count} !== {1'b1, 16'hFFFF}) begin fails++; $display("FAIL miss_saturate%0d done0/count got %b/%h want 1/ffff", j, done0, miss_count); end
            cache_miss = 1'b0; cache_fetchComplete = 1'b0; req0 = 1'b0;
            tick();
        end
    endtask

    task automatic test_timeout();
        int n, guard;
        req0 = 1'b1; write0 = 1'b0; addr0 = 10'h0F0;
        tick();
        req1 = 1'b1; write1 = 1'b0; addr1 = 10'h055;
        n = 0; guard = 0;
        while (!done0 && guard < 300) begin
            n += int'(cache_enable);
            guard++;
            tick();
        end
        tests++; if (n !== 255) begin fails++; $display("FAIL timeout_cycles got %0d want 255", n); end
        tests++; if ({done0, err0, done1, err1, cache_enable} !== 5'b11000) begin fails++; $display("FAIL timeout_pulse d0/e0/d1/e1/en got %b want 11000", {done0, err0, done1, err1, cache_enable}); end
        tests++; if (rdata0 !== 8'h5A) begin fails++; $display("FAIL timeout_rdata0 got %h want 5a", rdata0); end
        req0 = 1'b0;
        tick();
        tests++; if ({err0, busy} !== 2'b00) begin fails++; $display("FAIL timeout_idle err0/busy got %b want 00", {err0, busy}); end
        tick();
        tests++; if ({owner, cache_enable, cache_addr} !== {2'b11, 10'h055}) begin fails++; $display("FAIL timeout_next owner/en/addr got %b/%b/%h want 1/1/055", owner, cache_enable, cache_addr); end
        cache_fetchComplete = 1'b1; cache_rdata = 8'hC3;
        tick();
        tests++; if ({done1, err1, rdata1} !== {2'b10, 8'hC3}) begin fails++; $display("FAIL timeout_serve1 done1/err1/rdata1 got %b/%b/%h want 1/0/c3", done1, err1, rdata1); end
        cache_fetchComplete = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        req0 = 1'b1; write0 = 1'b0; addr0 = 10'h0AA;
        tick();
        tick();
        tests++; if (cache_enable !== 1'b1) begin fails++; $display("FAIL areset_pre_en got %b want 1", cache_enable); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if ({cache_enable, busy, done0, done1} !== 4'b0000) begin fails++; $display("FAIL areset_now en/busy/d0/d1 got %b want 0000", {cache_enable, busy, done0, done1}); end
        tests++; if (rdata1 !== 8'h00) begin fails++; $display("FAIL areset_rdata1 got %h want 00", rdata1); end
        req0 = 1'b0; req1 = 1'b1;
        tick();
        tests++; if ({done0, busy} !== 2'b00) begin fails++; $display("FAIL areset_hold done0/busy got %b want 00", {done0, busy}); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tests++; if ({owner, cache_enable, busy, done0} !== 4'b1110) begin fails++; $display("FAIL areset_regrant owner/en/busy/done0 got %b want 1110", {owner, cache_enable, busy, done0}); end
        cache_fetchComplete = 1'b1; cache_rdata = 8'h3C;
        tick();
        tests++; if ({done1, rdata1} !== {1'b1, 8'h3C}) begin fails++; $display("FAIL areset_done1 done1/rdata1 got %b/%h want 1/3c", done1, rdata1); end
        cache_fetchComplete = 1'b0; req1 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_miss();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
